// File: rtl/rx_fcs_check.sv
// rx_fcs_check
//
// Ethernet receive-path stage that checks and strips the 4-byte CRC-32 FCS.
// Every byte goes through a 4-byte delay line. When the frame ends, the 4
// bytes still held in the line are the FCS, so they are never output. At the
// same edge, a one-cycle error pulse reports a CRC mismatch or a runt frame
// (fewer than 5 bytes). With i_en=0 the block passes bytes through with a
// latency of one i_ce cycle.
//
// Parameters:
//   RESIDUE       CRC register value that a correct frame leaves after all of
//                 its data and FCS bytes (right-shifting form, no final xor).
//
// Ports:
//   i_clk         clock
//   i_reset       synchronous, active-high reset
//   i_ce          byte-clock enable; state and outputs move only when it is high
//   i_en          1 = check and strip the FCS, 0 = pass-through
//   i_v, i_d      input byte valid / data byte (LSB first on the wire)
//   o_v, o_d      output byte valid / data byte
//   o_err         end-of-frame error pulse, one i_ce cycle long
//   o_bad_frames  count of o_err pulses, saturating (only when
//                 RX_FCS_ERRCNT_EN is defined)
//
// Build option: define RX_FCS_ERRCNT_EN to add the o_bad_frames counter.
//
// Handshake: there is no backpressure. A byte is transferred on each i_ce
// cycle where valid is high, and valid stays high for the whole contiguous
// frame. The output follows the same rule, and o_v/o_d/o_err hold their
// values between i_ce cycles.
//
// The FSM state register (state_q) is a named signal of the state_t enum, so
// checkers can bind to it directly.

module rx_fcs_check #(
  parameter logic [31:0] RESIDUE = 32'hdebb20e3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic        i_en,
  input  logic        i_v,
  input  logic [7:0]  i_d,
  output logic        o_v,
  output logic [7:0]  o_d,
  output logic        o_err
`ifdef RX_FCS_ERRCNT_EN
  ,
  output logic [15:0] o_bad_frames
`endif
);

  // S_BLOCKED: after reset, ignore bytes until i_v has been seen low.
  // S_IDLE:    between frames; the next i_v=1 starts a frame.
  // S_FRAME:   inside a frame.
  typedef enum logic [1:0] {
    S_BLOCKED = 2'd0,
    S_IDLE    = 2'd1,
    S_FRAME   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d, crc_byte;
  logic [3:0][7:0]  line_q, line_d;   // line_q[3] is the oldest byte
  logic [2:0]       cnt_q, cnt_d;     // bytes seen this frame, saturates at 5
  logic             o_v_d;
  logic [7:0]       o_d_d;
  logic             o_err_d;
`ifdef RX_FCS_ERRCNT_EN
  logic [15:0]      bad_q, bad_d;
`endif

  function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_byte = crc32_byte(crc_q, i_d);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    o_v_d   = o_v;
    o_d_d   = o_d;
    o_err_d = o_err;
`ifdef RX_FCS_ERRCNT_EN
    bad_d   = bad_q;
`endif
    if (i_ce) begin
      // The error pulse and output valid last only one i_ce cycle.
      o_err_d = 1'b0;
      o_v_d   = 1'b0;
      case (state_q)
        S_BLOCKED: begin
          crc_d = 32'hffffffff;
          cnt_d = 3'd0;
          if (!i_v) state_d = S_IDLE;
        end
        S_IDLE, S_FRAME: begin
          if (i_v) begin
            // In S_IDLE the CRC register is already all-ones and the counter
            // is zero, so a frame start takes the same path as a mid-frame byte.
            state_d = S_FRAME;
            crc_d   = crc_byte;
            line_d  = {line_q[2:0], i_d};
            cnt_d   = (cnt_q == 3'd5) ? 3'd5 : cnt_q + 3'd1;
            if (!i_en) begin
              o_v_d = 1'b1;
              o_d_d = i_d;
            end else if (cnt_q >= 3'd4) begin
              o_v_d = 1'b1;
              o_d_d = line_q[3];
            end
          end else begin
            // Frame end. The FCS bytes stay in the line and are dropped.
            // crc_q already includes the last accepted byte.
            if (state_q == S_FRAME && i_en) begin
              o_err_d = (crc_q != RESIDUE) || (cnt_q < 3'd5);
`ifdef RX_FCS_ERRCNT_EN
              if (o_err_d && bad_q != 16'hffff) bad_d = bad_q + 16'd1;
`endif
            end
            state_d = S_IDLE;
            crc_d   = 32'hffffffff;
            cnt_d   = 3'd0;
          end
        end
        default: state_d = S_BLOCKED;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_BLOCKED;
      crc_q   <= 32'hffffffff;
      line_q  <= '0;
      cnt_q   <= 3'd0;
      o_v     <= 1'b0;
      o_d     <= 8'h00;
      o_err   <= 1'b0;
`ifdef RX_FCS_ERRCNT_EN
      bad_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      o_v     <= o_v_d;
      o_d     <= o_d_d;
      o_err   <= o_err_d;
`ifdef RX_FCS_ERRCNT_EN
      bad_q   <= bad_d;
`endif
    end
  end

`ifdef RX_FCS_ERRCNT_EN
  assign o_bad_frames = bad_q;
`endif

endmodule

// File: tb/tb_rx_fcs_check.sv
// Directed bench for rx_fcs_check: good, corrupt, runt, bypass, throttled-ce,
// reset mid-frame and random frames. Expected output bytes are queued when
// driven and popped when o_v is seen.
module tb_rx_fcs_check;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_reset, i_ce, i_en, i_v;
  logic [7:0]  i_d;
  logic        o_v, o_err;
  logic [7:0]  o_d;
`ifdef RX_FCS_ERRCNT_EN
  logic [15:0] o_bad_frames;
`endif

  always #5 i_clk = ~i_clk;

  rx_fcs_check dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_en    (i_en),
    .i_v     (i_v),
    .i_d     (i_d),
    .o_v     (o_v),
    .o_d     (o_d),
    .o_err   (o_err)
`ifdef RX_FCS_ERRCNT_EN
    ,
    .o_bad_frames (o_bad_frames)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] frame_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       last_exp_v   = 1'b0;
  logic [7:0] last_exp_d   = 8'h00;
  logic       last_exp_err = 1'b0;
  int         exp_bad      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hedb88320;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // One accepted byte time: 'gap' clocks with i_ce low (outputs must hold),
  // then one clock with i_ce high, then the output checks.
  task automatic step(input logic v, input logic [7:0] d, input int gap,
                      input logic exp_v, input logic exp_err);
    i_ce = 1'b0;
    for (int k = 0; k < gap; k++) begin
      @(posedge i_clk); #1;
      chk("hold_v", {31'b0, o_v}, {31'b0, last_exp_v});
      chk("hold_err", {31'b0, o_err}, {31'b0, last_exp_err});
      if (last_exp_v) chk("hold_d", {24'b0, o_d}, {24'b0, last_exp_d});
    end
    i_ce = 1'b1; i_v = v; i_d = d;
    @(posedge i_clk); #1;
    i_ce = 1'b0;
    chk("o_v", {31'b0, o_v}, {31'b0, exp_v});
    chk("o_err", {31'b0, o_err}, {31'b0, exp_err});
    if (exp_v) begin
      chk("out_avail", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        last_exp_d = exp_q.pop_front();
        chk("o_d", {24'b0, o_d}, {24'b0, last_exp_d});
      end
    end
    last_exp_v   = exp_v;
    last_exp_err = exp_err;
  endtask

  // Sends frame_q, then the frame-end cycle and one idle cycle.
  task automatic run_frame(input logic en, input int gap, input logic exp_err);
    int n;
    n = frame_q.size();
    i_en = en;
    for (int i = 0; i < n; i++) begin
      if (!en || i < n - 4) exp_q.push_back(frame_q[i]);
      step(1'b1, frame_q[i], gap, (!en) || (i >= 4), 1'b0);
    end
    step(1'b0, 8'h00, gap, 1'b0, exp_err);
    if (exp_err) exp_bad++;
    chk("drained", exp_q.size(), 32'd0);
`ifdef RX_FCS_ERRCNT_EN
    chk("bad_frames", {16'b0, o_bad_frames}, exp_bad);
`endif
    step(1'b0, 8'h00, gap, 1'b0, 1'b0);
  endtask

  task automatic load_good();
    frame_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hf4, 8'hcb};
  endtask

  task automatic load_random();
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    c = 32'hffffffff;
    frame_q = {};
    n = $urandom_range(20, 5);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(255, 0));
      frame_q.push_back(b);
      c = ref_crc(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frame_q.push_back(c[8*i +: 8]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    i_reset = 1'b1; i_ce = 1'b0; i_en = 1'b1; i_v = 1'b0; i_d = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_o_v", {31'b0, o_v}, 32'd0);
    chk("rst_o_d", {24'b0, o_d}, 32'd0);
    chk("rst_o_err", {31'b0, o_err}, 32'd0);
`ifdef RX_FCS_ERRCNT_EN
    chk("rst_bad", {16'b0, o_bad_frames}, 32'd0);
`endif
    i_reset = 1'b0;
    step(1'b0, 8'h00, 0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Good frame "123456789" + FCS.
    load_good();
    run_frame(1'b1, 0, 1'b0);

    // Corrupt fifth byte.
    load_good();
    frame_q[4] = 8'h34;
    run_frame(1'b1, 0, 1'b1);

    // Runt frame.
    frame_q = {8'h01, 8'h02, 8'h03};
    run_frame(1'b1, 0, 1'b1);

    // Bypass: all 13 bytes out, no error.
    load_good();
    run_frame(1'b0, 0, 1'b0);

    // Throttled clock enable: i_ce every third clock.
    load_good();
    run_frame(1'b1, 2, 1'b0);

    // Reset mid-frame after byte 6, released with i_v still high.
    load_good();
    i_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 2) exp_q.push_back(frame_q[i]);
      step(1'b1, frame_q[i], 0, i >= 4, 1'b0);
    end
    i_reset = 1'b1; i_ce = 1'b1; i_v = 1'b1; i_d = frame_q[6];
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    chk("midrst_o_v", {31'b0, o_v}, 32'd0);
    chk("midrst_o_err", {31'b0, o_err}, 32'd0);
    last_exp_v = 1'b0; last_exp_err = 1'b0;
    for (int i = 7; i < 13; i++) step(1'b1, frame_q[i], 0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 0, 1'b0, 1'b0);
    chk("midrst_drained", exp_q.size(), 32'd0);
    load_good();
    run_frame(1'b1, 0, 1'b0);

    // Random good frames, then a random single-bit corruption.
    for (int r = 0; r < 3; r++) begin
      load_random();
      run_frame(1'b1, $urandom_range(1, 0), 1'b0);
    end
    load_random();
    idx = $urandom_range(frame_q.size() - 1, 0);
    frame_q[idx] = frame_q[idx] ^ (8'h01 << $urandom_range(7, 0));
    run_frame(1'b1, 0, 1'b1);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_fcs_check.md
# rx_fcs_check

Ethernet receive-path stage that verifies and strips the 4-byte frame check sequence (CRC-32 FCS) from the incoming byte stream. It sits after the preamble/SFD stripper and directly feeds the minimum-length filter. Frames leave with the FCS removed. A one-cycle error pulse at end-of-frame flags a CRC mismatch or a truncated frame, so downstream stages can cancel the packet.

## Interface
- `RESIDUE`, default 32'hdebb20e3: CRC register value that a correct frame leaves after all data and FCS bytes are processed (right-shifting form).
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_ce`  in  1  byte-clock enable. Inputs are sampled, and state and outputs change, only on `i_ce` cycles.
- `i_en`  in  1  1 = check and strip FCS; 0 = pass-through. Stable for the whole frame.
- `i_v`  in  1  byte valid; high for the whole contiguous frame.
- `i_d`  in  8  data byte, LSB first on the wire.
- `o_v`  out  1  output byte valid.
- `o_d`  out  8  output byte.
- `o_err`  out  1  end-of-frame error pulse (CRC bad or frame too short).

## Operation
- CRC-32, reflected polynomial 32'hedb88320, processed one byte per accepted cycle. Register initialises to 32'hffffffff at frame start.
- Frame start is the first `i_ce` cycle with `i_v`=1 following a cycle with `i_v`=0. Frame end is the first `i_ce` cycle with `i_v`=0 following `i_v`=1.
- **Delay line:** a 4-byte shift register plus a fill counter (3 bits, saturating at 5).
  - The counter is cleared at frame end and while idle.
  - Each accepted byte shifts in.
  - When the line already holds 4 bytes, the oldest byte is emitted on `o_d` with `o_v`=1. Otherwise `o_v`=0.
- **At frame end, enabled:**
  - The 4 bytes left in the line are the FCS. They are discarded and never output.
  - `o_v` goes to 0.
  - `o_err` is set to 1 if the CRC register differs from `RESIDUE`, or if fewer than 5 bytes were received. Otherwise `o_err` is 0.
- **Disabled (`i_en`=0):**
  - Each accepted byte is output on the next edge: `o_v`<=`i_v`, `o_d`<=`i_d`.
  - No bytes are stripped and `o_err` stays 0.
  - The CRC and counter still run but are ignored.
- `o_err` is high for exactly one `i_ce` cycle. It clears on the next `i_ce` cycle.
- Upstream guarantees `i_v`=0 on the `i_ce` cycle after an `o_err` (interframe gap ≥ 2 byte times). `i_v` returning high in that cycle starts a new frame normally.
- Idle (`i_v`=0 for consecutive `i_ce` cycles): `o_v`=0, `o_err`=0, CRC register = 32'hffffffff.

## Timing
- All outputs are registered and hold their value on non-`i_ce` cycles. Downstream samples them on its next `i_ce` cycle.
- Enabled latency: byte n appears on `o_d` at the edge of the `i_ce` cycle that accepts byte n+4.
- Disabled latency: 1 `i_ce` cycle.
- `o_err` is registered at the edge of the frame-end `i_ce` cycle, the same edge at which `o_v` falls.
- The CRC compare uses the register value after the last accepted byte. The compare is registered with the frame-end decision, adding no extra cycle.
- Reset values: `o_v`=0, `o_d`=0, `o_err`=0, counter=0, CRC=32'hffffffff, delay line=0.
- Reset mid-frame:
  - Outputs clear on the next edge.
  - Bytes still arriving with `i_v`=1 after reset release are not treated as a frame. The block waits for `i_v`=0 on an `i_ce` cycle before accepting a new frame start.
- `i_ce` gaps inside a frame are legal at any duty cycle and must not change the output byte sequence.

## Configuration
- `RX_FCS_ERRCNT_EN`:
  - Defined: adds output `o_bad_frames` [15:0], which counts `o_err` pulses.
    - Saturates at 16'hffff.
    - Reset value 0.
    - Increments on the same edge that `o_err` rises.
  - Undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- **Good frame:** `i_en`=1, `i_ce`=1, bytes 0x31..0x39 ("123456789") then FCS 0x26 0x39 0xf4 0xcb → `o_v` high for exactly 9 cycles carrying 0x31..0x39 starting 4 cycles after the first byte; `o_err`=0 throughout.
- **Corrupt byte:** same frame with the fifth byte 0x35 changed to 0x34 → identical 9-byte output sequence except that byte; one-cycle `o_err`=1 at frame end.
- **Runt frame:** 3-byte frame 0x01 0x02 0x03 → `o_v` never high; `o_err`=1 for one `i_ce` cycle.
- **Bypass:** `i_en`=0, good 13-byte frame → all 13 bytes output with 1-cycle latency; `o_err`=0.
- **Throttled clock enable:** good frame with `i_ce` high every third clock → same 9 output bytes; `o_v`/`o_d` held between enables; no error.
- **Reset mid-frame:** assert `i_reset` after byte 6, release with `i_v` still high → `o_v`=0 and `o_err`=0 until `i_v` drops; the next good frame passes cleanly. With `RX_FCS_ERRCNT_EN`, a corrupt frame followed by a runt frame gives `o_bad_frames`=2.
